// File: rtl/regfile_dump.sv
// Debug read-out path: walks a register range through one combinational
// register-file read port and streams each value over valid/ready.
// Optional REGFILE_DUMP_PARITY_EN adds a registered even-parity output.
module regfile_dump #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SEL_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SEL_WIDTH-1:0]  first_sel,
  input  logic [SEL_WIDTH-1:0]  last_sel,
  output logic [SEL_WIDTH-1:0]  rf_sel,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [SEL_WIDTH-1:0]  dump_idx,
  output logic [DATA_WIDTH-1:0] dump_data,
`ifdef REGFILE_DUMP_PARITY_EN
  output logic                  dump_parity,
`endif
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] idx_q, idx_d;
  logic [SEL_WIDTH-1:0] last_q, last_d;
  logic [SEL_WIDTH-1:0] sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = first_sel;
          last_d  = last_sel;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = abort ? IDLE : SEND;
      end
      SEND: begin
        // abort takes priority over a simultaneous handshake
        if (abort) begin
          state_d = IDLE;
        end else if (dump_ready) begin
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read port is combinational, so the select must be live during FETCH;
  // sel_q keeps the last driven select visible in every other state.
  assign rf_sel     = (state_q == FETCH) ? idx_q : sel_q;
  assign dump_valid = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      dump_idx    <= '0;
      dump_data   <= '0;
`ifdef REGFILE_DUMP_PARITY_EN
      dump_parity <= 1'b0;
`endif
    end else if (state_q == FETCH) begin
      sel_q       <= idx_q;
      dump_idx    <= idx_q;
      dump_data   <= rf_data;
`ifdef REGFILE_DUMP_PARITY_EN
      dump_parity <= ^rf_data;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed self-checking bench for regfile_dump with a behavioural
// combinational register file; parity checks run when REGFILE_DUMP_PARITY_EN is set.
module tb_regfile_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  first_sel;
  logic [4:0]  last_sel;
  logic [4:0]  rf_sel;
  logic [63:0] rf_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [63:0] dump_data;
  logic        busy;
  logic        done;
`ifdef REGFILE_DUMP_PARITY_EN
  logic        dump_parity;
`endif

  logic [63:0] regs [32];
  assign rf_data = regs[rf_sel];

  regfile_dump #(
    .DATA_WIDTH(64),
    .SEL_WIDTH (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_sel (first_sel),
    .last_sel  (last_sel),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_idx  (dump_idx),
    .dump_data (dump_data),
`ifdef REGFILE_DUMP_PARITY_EN
    .dump_parity(dump_parity),
`endif
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Words accepted during one dump, gathered by collect().
  logic [4:0]  q_idx  [$];
  logic [63:0] q_data [$];
  int          q_cyc  [$];
  bit          q_par  [$];
  int          done_cnt;
  int          done_cyc;
  int          first_valid;
  int          busy_cnt;
  bit          timed_out;

  // Called right after a negedge with the DUT idle; returns one negedge later.
  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    start     = 1'b1;
    first_sel = f;
    last_sel  = l;
    @(negedge clk);
    start     = 1'b0;
    first_sel = ~f;
    last_sel  = ~l;
  endtask

  // Samples once per negedge until busy drops; stall_first refuses the first offered word once.
  task automatic collect(input int budget, input bit stall_first);
    bit stalled = 1'b0;
    q_idx.delete(); q_data.delete(); q_cyc.delete(); q_par.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; busy_cnt = 0; timed_out = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cnt++;
      dump_ready = 1'b1;
      if (dump_valid && stall_first && !stalled) begin
        dump_ready = 1'b0;
        stalled    = 1'b1;
      end
      if (dump_valid && first_valid < 0) first_valid = c;
      if (dump_valid && dump_ready) begin
        q_idx.push_back(dump_idx);
        q_data.push_back(dump_data);
        q_cyc.push_back(c);
`ifdef REGFILE_DUMP_PARITY_EN
        q_par.push_back(dump_parity);
`else
        q_par.push_back(1'b0);
`endif
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      @(negedge clk);
    end
    dump_ready = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dump_valid); end
    n_checks++; if (rf_sel !== 5'd0) begin n_fail++; $display("FAIL reset_rf_sel: got %0d expected 0", rf_sel); end
    n_checks++; if (dump_idx !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", dump_idx); end
    n_checks++; if (dump_data !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", dump_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_range;
    bit bad_gap = 1'b0;
    dump_ready = 1'b1;
    do_start(5'd0, 5'd31);
    collect(100, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %b expected 0", timed_out); end
    n_checks++; if (q_idx.size() != 32) begin n_fail++; $display("FAIL full_count: got %0d expected 32", q_idx.size()); end
    n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL full_first_valid: got cycle %0d expected 2", first_valid); end
    for (int i = 0; i < q_idx.size(); i++) begin
      n_checks++; if (q_idx[i] !== 5'(i)) begin n_fail++; $display("FAIL full_idx[%0d]: got %0d expected %0d", i, q_idx[i], i); end
      n_checks++; if (q_data[i] !== regs[i]) begin n_fail++; $display("FAIL full_data[%0d]: got %h expected %h", i, q_data[i], regs[i]); end
      if (i > 0 && q_cyc[i] - q_cyc[i-1] != 2) bad_gap = 1'b1;
    end
    if (q_idx.size() == 32) begin
      n_checks++; if (q_data[0] !== 64'h1234567812345678) begin n_fail++; $display("FAIL full_reg0: got %h expected 1234567812345678", q_data[0]); end
      n_checks++; if (q_data[31] !== 64'h00000000ffffffff) begin n_fail++; $display("FAIL full_reg31: got %h expected 00000000ffffffff", q_data[31]); end
      n_checks++; if (done_cyc != q_cyc[31] + 1) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected %0d", done_cyc, q_cyc[31] + 1); end
    end
    n_checks++; if (bad_gap !== 1'b0) begin n_fail++; $display("FAIL full_word_spacing: got irregular gap expected 2 cycles"); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_single;
    regs[5] = 64'h534642;
    dump_ready = 1'b1;
    do_start(5'd5, 5'd5);
    collect(20, 1'b1);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b expected 0", timed_out); end
    n_checks++; if (q_idx.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", q_idx.size()); end
    if (q_idx.size() >= 1) begin
      n_checks++; if (q_idx[0] !== 5'd5) begin n_fail++; $display("FAIL single_idx: got %0d expected 5", q_idx[0]); end
      n_checks++; if (q_data[0] !== 64'h534642) begin n_fail++; $display("FAIL single_data: got %h expected 534642", q_data[0]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (busy_cnt != 4) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected 4", busy_cnt); end
  endtask

  task automatic test_wrap;
    logic [4:0] exp_w [4];
    exp_w = '{5'd30, 5'd31, 5'd0, 5'd1};
    dump_ready = 1'b1;
    do_start(5'd30, 5'd1);
    collect(30, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: got %b expected 0", timed_out); end
    n_checks++; if (q_idx.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", q_idx.size()); end
    for (int i = 0; i < q_idx.size() && i < 4; i++) begin
      n_checks++; if (q_idx[i] !== exp_w[i]) begin n_fail++; $display("FAIL wrap_idx[%0d]: got %0d expected %0d", i, q_idx[i], exp_w[i]); end
      n_checks++; if (q_data[i] !== regs[exp_w[i]]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, q_data[i], regs[exp_w[i]]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_hold;
    logic [63:0] old5;
    old5 = regs[5];
    dump_ready = 1'b1;
    do_start(5'd4, 5'd6);
    n_checks++; if (rf_sel !== 5'd4) begin n_fail++; $display("FAIL hold_fetch_sel4: got %0d expected 4", rf_sel); end
    @(negedge clk);
    n_checks++; if (dump_valid !== 1'b1 || dump_idx !== 5'd4) begin n_fail++; $display("FAIL hold_word4: got valid %b idx %0d expected valid 1 idx 4", dump_valid, dump_idx); end
    @(negedge clk);
    dump_ready = 1'b0;
    n_checks++; if (rf_sel !== 5'd5 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL hold_fetch5: got sel %0d valid %b expected sel 5 valid 0", rf_sel, dump_valid); end
    @(negedge clk);
    n_checks++; if (rf_sel !== 5'd5) begin n_fail++; $display("FAIL hold_sel_held: got %0d expected 5", rf_sel); end
    // A start while busy must be ignored.
    start = 1'b1; first_sel = 5'd20; last_sel = 5'd20;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) start = 1'b0;
      if (k == 2) regs[5] = 64'hDEADBEEF00000005;
      n_checks++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'd5 || dump_data !== old5) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got valid %b idx %0d data %h expected valid 1 idx 5 data %h", k, dump_valid, dump_idx, dump_data, old5);
      end
      @(negedge clk);
    end
    dump_ready = 1'b1;
    n_checks++; if (dump_data !== old5) begin n_fail++; $display("FAIL hold_data_at_accept: got %h expected %h", dump_data, old5); end
    @(negedge clk);
    n_checks++; if (rf_sel !== 5'd6 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL hold_fetch6: got sel %0d valid %b expected sel 6 valid 0", rf_sel, dump_valid); end
    @(negedge clk);
    n_checks++; if (dump_valid !== 1'b1 || dump_idx !== 5'd6 || dump_data !== regs[6]) begin n_fail++; $display("FAIL hold_word6: got valid %b idx %0d data %h expected 1 6 %h", dump_valid, dump_idx, dump_data, regs[6]); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b expected 1", done); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got busy %b done %b expected 0 0", busy, done); end
  endtask

  task automatic test_abort;
    bit saw_done = 1'b0;
    dump_ready = 1'b1;
    do_start(5'd10, 5'd13);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (dump_valid !== 1'b1 || dump_idx !== 5'd11) begin n_fail++; $display("FAIL abort_second_word: got valid %b idx %0d expected 1 11", dump_valid, dump_idx); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (dump_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_to_idle: got valid %b busy %b expected 0 0", dump_valid, busy); end
    for (int k = 0; k < 4; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got done pulse expected none"); end
    // abort in IDLE has no effect on a start in the same cycle
    abort = 1'b1;
    do_start(5'd0, 5'd0);
    abort = 1'b0;
    collect(20, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL restart_timeout: got %b expected 0", timed_out); end
    n_checks++; if (q_idx.size() != 1) begin n_fail++; $display("FAIL restart_count: got %0d expected 1", q_idx.size()); end
    if (q_idx.size() >= 1) begin
      n_checks++; if (q_idx[0] !== 5'd0) begin n_fail++; $display("FAIL restart_idx: got %0d expected 0", q_idx[0]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_send;
    bit saw_activity = 1'b0;
    dump_ready = 1'b0;
    do_start(5'd3, 5'd3);
    @(negedge clk);
    n_checks++; if (dump_valid !== 1'b1 || dump_idx !== 5'd3) begin n_fail++; $display("FAIL rst_mid_pre: got valid %b idx %0d expected 1 3", dump_valid, dump_idx); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got valid %b busy %b done %b expected 0 0 0", dump_valid, busy, done); end
    n_checks++; if (rf_sel !== 5'd0 || dump_idx !== 5'd0 || dump_data !== 64'd0) begin n_fail++; $display("FAIL rst_mid_data: got sel %0d idx %0d data %h expected 0 0 0", rf_sel, dump_idx, dump_data); end
    @(negedge clk);
    rst_n = 1'b1;
    dump_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || busy) saw_activity = 1'b1;
    end
    n_checks++; if (saw_activity !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet: got busy/done after reset expected idle"); end
  endtask

`ifdef REGFILE_DUMP_PARITY_EN
  task automatic test_parity;
    regs[7] = 64'h7;
    regs[8] = 64'h3;
    dump_ready = 1'b1;
    do_start(5'd7, 5'd8);
    collect(20, 1'b0);
    n_checks++; if (q_par.size() != 2) begin n_fail++; $display("FAIL parity_count: got %0d expected 2", q_par.size()); end
    if (q_par.size() == 2) begin
      n_checks++; if (q_par[0] !== 1'b1) begin n_fail++; $display("FAIL parity_reg7: got %b expected 1", q_par[0]); end
      n_checks++; if (q_par[1] !== 1'b0) begin n_fail++; $display("FAIL parity_reg3val: got %b expected 0", q_par[1]); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    first_sel = '0; last_sel = '0; dump_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = {16'hC0DE, 16'(i), 16'hBEEF, 16'(i)};
    regs[0]  = 64'h1234567812345678;
    regs[31] = 64'h00000000ffffffff;
    test_reset();
    test_full_range();
    test_single();
    test_wrap();
    test_hold();
    test_abort();
    test_reset_mid_send();
`ifdef REGFILE_DUMP_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
